bram_port_arbiter: RTL and testbench

Parametrised multi-channel front end for one port of a block RAM (the "a" side of a BlockRamConnection-style link).
- CHANNELS independent requesters share the single RAM port through a round-robin arbiter, one access per cycle.
- Each read response is routed back to the channel that issued it, after a configurable RAM read latency.
- Sits between parser/tape-writer stages and a shared BRAM, so several stages can use one memory without external muxing.

---
 rtl/bram_port_arbiter.sv | 136 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one block-RAM port among CHANNELS independent requesters. A
// round-robin arbiter grants one request per cycle, the grant is registered
// onto the RAM port, and each read is tagged so that its data can be steered
// back to the issuing channel READ_LATENCY cycles after the RAM enable.
//
// Ports:
//   clk, rst         single rising-edge clock, asynchronous active-high reset
//   req_valid/we     per-channel request pending / write(1) or read(0)
//   req_addr/wdata   packed per-channel address and write data
//   req_ready        one-hot grant; a request is accepted on valid & ready
//   rsp_valid        one-hot read-data strobe for the issuing channel
//   rsp_data         read data shared by all channels, held between strobes
//   ram_en/we/addr/di  registered RAM port controls and write data
//   ram_do           RAM read data, valid READ_LATENCY cycles after ram_en
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int WORDSIZE     = 8,
    parameter int ADDRWIDTH    = 9,
    parameter int CHANNELS     = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           req_valid,
    input  logic [CHANNELS-1:0]           req_we,
    input  logic [CHANNELS*ADDRWIDTH-1:0] req_addr,
    input  logic [CHANNELS*WORDSIZE-1:0]  req_wdata,
    output logic [CHANNELS-1:0]           req_ready,
    output logic [CHANNELS-1:0]           rsp_valid,
    output logic [WORDSIZE-1:0]           rsp_data,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDRWIDTH-1:0]          ram_addr,
    output logic [WORDSIZE-1:0]           ram_di,
    input  logic [WORDSIZE-1:0]           ram_do
);

    localparam int IDW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // One entry per issued access; only reads ever produce a response.
    typedef struct packed {
        logic           is_read;
        logic [IDW-1:0] id;
    } trk_t;

    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       next_ptr;
    logic [IDW-1:0]       grant_id;
    logic                 grant_any;
    logic                 sel_we;
    logic [ADDRWIDTH-1:0] sel_addr;
    logic [WORDSIZE-1:0]  sel_wdata;
    logic [WORDSIZE-1:0]  rsp_data_q;
    trk_t                 trk [0:READ_LATENCY];

    // Round-robin search: walk the channels starting at the pointer, wrapping
    // modulo CHANNELS, and take the first one with a pending request.
    always_comb begin : arbitrate
        int idx;
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant_any = 1'b0;
        grant_id  = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        idx       = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(idx);
                sel_we    = req_we[idx];
                sel_addr  = req_addr[idx*ADDRWIDTH +: ADDRWIDTH];
                sel_wdata = req_wdata[idx*WORDSIZE +: WORDSIZE];
            end
        end
    end

    assign next_ptr  = (grant_id == IDW'(CHANNELS - 1)) ? '0 : grant_id + 1'b1;

    // Grant is purely combinational; forced low while reset is held.
    assign req_ready = (grant_any && !rst) ? (CHANNELS'(1) << grant_id) : '0;

    // Issue stage: the grant of this cycle becomes the RAM access of the next.
    // Address and write data hold when idle so the port does not toggle.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_di   <= '0;
        end else begin
            ram_en <= grant_any;
            ram_we <= grant_any && sel_we;
            if (grant_any) begin
                ptr      <= next_ptr;
                ram_addr <= sel_addr;
                ram_di   <= sel_wdata;
            end
        end
    end

    // Response tracker: stage 0 lines up with ram_en, stage READ_LATENCY
    // lines up with valid ram_do.
    // NOTE: this small tag pipeline is reset on purpose so that reads in
    // flight at reset are dropped; a real data memory would not be reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= READ_LATENCY; k++) trk[k] <= '0;
        end else begin
            trk[0] <= trk_t'{is_read: grant_any && !sel_we, id: grant_id};
            for (int k = 1; k <= READ_LATENCY; k++) trk[k] <= trk[k-1];
        end
    end

    // Last delivered word, so rsp_data holds between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data_q <= '0;
        end else if (trk[READ_LATENCY].is_read) begin
            rsp_data_q <= ram_do;
        end
    end

    assign rsp_valid = trk[READ_LATENCY].is_read ? (CHANNELS'(1) << trk[READ_LATENCY].id) : '0;
    assign rsp_data  = trk[READ_LATENCY].is_read ? ram_do : rsp_data_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Drives two arbiters from the same requesters: one with READ_LATENCY=1 (a)
// and one with READ_LATENCY=2 (b), each attached to its own behavioural RAM.
// A reference model tracks the round-robin pointer, a shadow of the memory
// contents, and a per-cycle table of the expected response strobes.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

    localparam int WS    = 8;
    localparam int AW    = 9;
    localparam int CH    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int NCYC  = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [CH-1:0]    req_valid;
    logic [CH-1:0]    req_we;
    logic [CH*AW-1:0] req_addr;
    logic [CH*WS-1:0] req_wdata;

    logic [CH-1:0] ready_a, rsp_valid_a, ready_b, rsp_valid_b;
    logic [WS-1:0] rsp_data_a, ram_di_a, ram_do_a, rsp_data_b, ram_di_b, ram_do_b, ram_do_b_s1;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;

    bram_port_arbiter #(.WORDSIZE(WS), .ADDRWIDTH(AW), .CHANNELS(CH), .READ_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_a),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .ram_en(ram_en_a),
        .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_di(ram_di_a), .ram_do(ram_do_a)
    );

    bram_port_arbiter #(.WORDSIZE(WS), .ADDRWIDTH(AW), .CHANNELS(CH), .READ_LATENCY(2)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .ram_en(ram_en_b),
        .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_di(ram_di_b), .ram_do(ram_do_b)
    );

    // Behavioural block RAMs (not reset), latency 1 and 2.
    logic [WS-1:0] mem_a [DEPTH];
    logic [WS-1:0] mem_b [DEPTH];

    always @(posedge clk) begin
        if (ram_en_a) begin
            if (ram_we_a) mem_a[ram_addr_a] <= ram_di_a;
            else          ram_do_a <= mem_a[ram_addr_a];
        end
    end

    always @(posedge clk) begin
        if (ram_en_b) begin
            if (ram_we_b) mem_b[ram_addr_b] <= ram_di_b;
            else          ram_do_b_s1 <= mem_b[ram_addr_b];
        end
        ram_do_b <= ram_do_b_s1;
    end

    // Reference model state.
    logic [WS-1:0] model_mem [DEPTH];
    logic [CH-1:0] exp_mask_a [NCYC];
    logic [WS-1:0] exp_data_a [NCYC];
    logic [CH-1:0] exp_mask_b [NCYC];
    logic [WS-1:0] exp_data_b [NCYC];
    int            ptr_m;
    int            cyc;
    logic          exp_en, exp_we;
    logic [AW-1:0] exp_addr;
    logic [WS-1:0] exp_di;
    bit            hold_reqs;
    int            grants_seen [CH];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    // One clock cycle: predict, sample on the falling edge, update model
    // after the rising edge, then release inputs for the next cycle.
    task automatic step();
        int            g;
        logic [CH-1:0] er;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < CH; k++) begin
                int idx;
                idx = (ptr_m + k) % CH;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        er = (g >= 0) ? (CH'(1) << g) : '0;

        @(negedge clk);
        chk("ready_a", 32'(ready_a), 32'(er));
        chk("ready_b", 32'(ready_b), 32'(er));
        chk("rsp_valid_a", 32'(rsp_valid_a), 32'(exp_mask_a[cyc]));
        chk("rsp_valid_b", 32'(rsp_valid_b), 32'(exp_mask_b[cyc]));
        if (exp_mask_a[cyc] != '0) chk("rsp_data_a", 32'(rsp_data_a), 32'(exp_data_a[cyc]));
        if (exp_mask_b[cyc] != '0) chk("rsp_data_b", 32'(rsp_data_b), 32'(exp_data_b[cyc]));
        if (rst) begin
            chk("rsp_data_rst_a", 32'(rsp_data_a), 32'd0);
            chk("rsp_data_rst_b", 32'(rsp_data_b), 32'd0);
        end
        chk("ram_en_a",   32'(ram_en_a),   32'(exp_en));
        chk("ram_en_b",   32'(ram_en_b),   32'(exp_en));
        chk("ram_we_a",   32'(ram_we_a),   32'(exp_we));
        chk("ram_addr_a", 32'(ram_addr_a), 32'(exp_addr));
        chk("ram_addr_b", 32'(ram_addr_b), 32'(exp_addr));
        chk("ram_di_a",   32'(ram_di_a),   32'(exp_di));
        for (int i = 0; i < CH; i++) if (ready_a[i]) grants_seen[i]++;

        @(posedge clk);
        if (g >= 0) begin
            ptr_m    = (g + 1) % CH;
            exp_en   = 1'b1;
            exp_we   = req_we[g];
            exp_addr = req_addr[g*AW +: AW];
            exp_di   = req_wdata[g*WS +: WS];
            if (req_we[g]) begin
                model_mem[exp_addr] = exp_di;
            end else begin
                exp_mask_a[cyc+2] = er;
                exp_data_a[cyc+2] = model_mem[exp_addr];
                exp_mask_b[cyc+3] = er;
                exp_data_b[cyc+3] = model_mem[exp_addr];
            end
        end else begin
            exp_en = 1'b0;
            exp_we = 1'b0;
        end
        cyc++;
        #1;
        if (g >= 0 && !hold_reqs) req_valid[g] = 1'b0;
    endtask

    // Asynchronous reset asserted now, held for n cycles, released off-edge.
    task automatic do_reset(input int n);
        rst      = 1'b1;
        ptr_m    = 0;
        exp_en   = 1'b0;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_di   = '0;
        for (int c = cyc; c < cyc + 8; c++) begin
            exp_mask_a[c] = '0;
            exp_mask_b[c] = '0;
        end
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic set_req(input int ch, input logic we, input logic [AW-1:0] a, input logic [WS-1:0] d);
        req_valid[ch]          = 1'b1;
        req_we[ch]             = we;
        req_addr[ch*AW +: AW]  = a;
        req_wdata[ch*WS +: WS] = d;
    endtask

    initial begin
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        hold_reqs = 1'b0;
        cyc       = 0;
        for (int i = 0; i < CH; i++) grants_seen[i] = 0;
        for (int c = 0; c < NCYC; c++) begin
            exp_mask_a[c] = '0; exp_data_a[c] = '0;
            exp_mask_b[c] = '0; exp_data_b[c] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            logic [WS-1:0] v;
            v = WS'($urandom);
            mem_a[i] = v; mem_b[i] = v; model_mem[i] = v;
        end
        mem_a[5] = 8'hA7; mem_b[5] = 8'hA7; model_mem[5] = 8'hA7;

        do_reset(2);

        // Single read from channel 2.
        set_req(2, 1'b0, 9'h005, 8'h00);
        repeat (5) step();

        // All four channels at once right after reset: back-to-back reads.
        do_reset(1);
        for (int i = 0; i < CH; i++) set_req(i, 1'b0, AW'(10 + i), 8'h00);
        repeat (8) step();

        // Fairness between two continuously requesting channels.
        for (int i = 0; i < CH; i++) grants_seen[i] = 0;
        hold_reqs = 1'b1;
        set_req(0, 1'b0, 9'h020, 8'h00);
        set_req(3, 1'b0, 9'h023, 8'h00);
        repeat (8) step();
        hold_reqs = 1'b0;
        req_valid = '0;
        chk("fair_ch0", 32'(grants_seen[0]), 32'd4);
        chk("fair_ch3", 32'(grants_seen[3]), 32'd4);
        repeat (4) step();

        // Write then read the top address from channel 1.
        set_req(1, 1'b1, 9'h1FF, 8'h3C);
        step();
        set_req(1, 1'b0, 9'h1FF, 8'h00);
        repeat (5) step();

        // Reset pulsed the cycle after a read grant: the read is dropped.
        set_req(0, 1'b0, 9'h007, 8'h00);
        step();
        do_reset(2);
        repeat (4) step();
        req_valid = '1;
        req_we    = '0;
        step();
        req_valid = '0;
        repeat (4) step();

        // Randomised traffic over a small address window to provoke hazards.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < CH; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 50)
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), WS'($urandom));
            end
            step();
        end
        req_valid = '0;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
